count_en_gen: RTL and testbench



---
 rtl/count_en_pkg.sv | 6 +
 rtl/en_debounce.sv | 37 +++
 rtl/count_en_gen.sv | 40 ++++
 tb/tb_count_en_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/count_en_pkg.sv
// count_en_pkg: shared defaults and mode encoding for the counter enable generator.
package count_en_pkg;
    localparam int DB_LEN_DEF = 4;
    localparam int PS_DIV_DEF = 8;
    localparam logic MODE_AUTO = 1'b1;
endpackage

// File: rtl/en_debounce.sv
// en_debounce: button synchroniser, debouncer and rising-commit pulse.
module en_debounce
    import count_en_pkg::*;
#(
    parameter int DB_W   = 3,
    parameter int DB_LEN = DB_LEN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic busy
);
    logic s1, s2, commit;
    logic [DB_W-1:0] db_cnt;
    assign commit = (s2 != level) && (db_cnt == DB_W'(DB_LEN - 1));
    // rise is combinational so the top can register en on the commit edge itself
    assign rise = commit && s2;
    assign busy = db_cnt != '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if (s2 == level) db_cnt <= '0;
            else if (commit) begin
                level  <= s2;
                db_cnt <= '0;
            end else db_cnt <= db_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/count_en_gen.sv
// count_en_gen: single-cycle enable pulses from a debounced button or a prescaler tick.
module count_en_gen
    import count_en_pkg::*;
#(
    parameter int DB_W   = 3,
    parameter int DB_LEN = DB_LEN_DEF,
    parameter int PS_W   = 3,
    parameter int PS_DIV = PS_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic auto,
    output logic en,
    output logic btn_level,
    output logic bouncing
);
    logic rise, wrap, auto_on;
    logic [PS_W-1:0] ps_cnt;
    en_debounce #(.DB_W(DB_W), .DB_LEN(DB_LEN)) u_db (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .level(btn_level),
        .rise (rise),
        .busy (bouncing)
    );
    assign auto_on = auto == MODE_AUTO;
    assign wrap    = ps_cnt == PS_W'(PS_DIV - 1);
    // in auto mode button commits still move btn_level but never reach en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt <= '0;
            en     <= 1'b0;
        end else begin
            ps_cnt <= auto_on ? (wrap ? '0 : ps_cnt + 1'b1) : '0;
            en     <= auto_on ? wrap : rise;
        end
    end
endmodule

// File: tb/tb_count_en_gen.sv
// tb_count_en_gen: directed checks of debounce, manual pulses, prescaler and mode changes.
module tb_count_en_gen;
    logic clk = 1'b0, rst = 1'b1, btn = 1'b0, auto = 1'b0;
    logic en, btn_level, bouncing;
    int errors = 0, checks = 0;

    count_en_gen dut (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .auto     (auto),
        .en       (en),
        .btn_level(btn_level),
        .bouncing (bouncing)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        btn  = 1'b0;
        auto = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        btn = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        checks++;
        if (bouncing !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_bouncing got=%b want=1", bouncing);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en, btn_level, bouncing} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async got=%b%b%b want=000", en, btn_level, bouncing);
        end
        btn = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (en !== 1'b0 || btn_level !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge=%0d en=%b lvl=%b want=0,0", i, en, btn_level);
            end
        end
    endtask

    task automatic test_press;
        do_reset();
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (en !== (i == 6) || btn_level !== (i >= 6) || bouncing !== (i >= 3 && i <= 5)) begin
                errors++;
                $display("FAIL press edge=%0d en=%b lvl=%b bnc=%b want=%b,%b,%b", i, en, btn_level,
                         bouncing, i == 6, i >= 6, i >= 3 && i <= 5);
            end
        end
    endtask

    task automatic test_release;
        btn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (en !== 1'b0 || btn_level !== (i < 6)) begin
                errors++;
                $display("FAIL release edge=%0d en=%b lvl=%b want=0,%b", i, en, btn_level, i < 6);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset();
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            tick();
            checks++;
            if (en !== 1'b0 || btn_level !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge=%0d en=%b lvl=%b want=0,0", i, en, btn_level);
            end
        end
        checks++;
        if (bouncing !== 1'b0) begin
            errors++;
            $display("FAIL glitch_bouncing got=%b want=0", bouncing);
        end
    endtask

    task automatic test_auto;
        do_reset();
        auto = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++;
            if (en !== (i == 8 || i == 16)) begin
                errors++;
                $display("FAIL auto edge=%0d en=%b want=%b", i, en, i == 8 || i == 16);
            end
        end
    endtask

    task automatic test_mode_change;
        do_reset();
        auto = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            checks++;
            if (en !== (i == 8 || i == 22)) begin
                errors++;
                $display("FAIL mode_change edge=%0d en=%b want=%b", i, en, i == 8 || i == 22);
            end
            if (i == 12) auto = 1'b0;
            if (i == 14) auto = 1'b1;
        end
    endtask

    task automatic test_interaction;
        do_reset();
        auto = 1'b1;
        tick();
        tick();
        btn = 1'b1;
        for (int i = 3; i <= 10; i++) begin
            tick();
            checks++;
            if (en !== (i == 8) || btn_level !== (i >= 8)) begin
                errors++;
                $display("FAIL interaction edge=%0d en=%b lvl=%b want=%b,%b", i, en, btn_level,
                         i == 8, i >= 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_auto();
        test_mode_change();
        test_interaction();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
